proc_control_unit: RTL

Control unit for the simple bus-based processor. It latches the instruction word from `din`, runs the 2-bit step counter (T0–T3), and drives the one-hot register, ALU and bus-select enables for the shared 16-bit bus and register file. It completes MV and MVI in two steps and ADD and SUB in four. It sits between the `run`/`din` inputs at `top` level and the datapath (R0–R7, A, G, adder/subtractor, bus mux).

---
 rtl/proc_control_unit_if.sv | 38 +++
 rtl/proc_control_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit_if.sv
// Bus-side interface of the processor control unit.
// Groups the run/din inputs and every datapath enable so the control unit
// and whoever drives it (top level or testbench) share one bundle.
interface proc_control_unit_if #(
  parameter int REG_WIDTH     = 16,
  parameter int COUNTER_WIDTH = 2
);

  logic                     run;
  logic [REG_WIDTH-1:0]     din;

  logic                     ir_in;
  logic [7:0]               r_in;
  logic [7:0]               r_out;
  logic                     din_out;
  logic                     a_in;
  logic                     g_in;
  logic                     g_out;
  logic [1:0]               alu_op;
  logic                     done;
  logic                     illegal;
  logic [COUNTER_WIDTH-1:0] step;

  // Driver side: supplies run/din and observes the control outputs
  modport master (
    output run, din,
    input  ir_in, r_in, r_out, din_out, a_in, g_in, g_out,
           alu_op, done, illegal, step
  );

  // Control-unit side: consumes run/din and drives the datapath enables
  modport slave (
    input  run, din,
    output ir_in, r_in, r_out, din_out, a_in, g_in, g_out,
           alu_op, done, illegal, step
  );

endinterface

// File: rtl/proc_control_unit.sv
// Control unit for the simple bus-based processor.
// Latches the instruction word in T0, steps T0..T3 and decodes the one-hot
// register, ALU and bus-select enables combinationally from step, IR, run
// and rst. MV/MVI finish in T1, ADD/SUB in T3.
// Optional feature macro: PROC_CTRL_AND_EN makes opcode 100 an AND that
// follows the ADD sequence; without it, opcode 100 is illegal.
module proc_control_unit #(
  parameter int REG_WIDTH         = 16,
  parameter int INSTRUCTION_WIDTH = 9,
  parameter int COUNTER_WIDTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  proc_control_unit_if.slave   bus
);

  // Step counter states; the counter is fixed at two bits
  typedef enum logic [COUNTER_WIDTH-1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  step_t                        step_q, step_d;
  logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [2:0] xSel;
  logic [2:0] ySel;
  logic       isArith;
  logic [1:0] arithAluOp;

  logic       irInVal;
  logic [7:0] rInVal;
  logic [7:0] rOutVal;
  logic       dinOutVal;
  logic       aInVal;
  logic       gInVal;
  logic       gOutVal;
  logic [1:0] aluOpVal;
  logic       doneVal;
  logic       illegalVal;

  // Only the low instruction bits of din are captured; the rest is data
  logic unusedDinBits;
  assign unusedDinBits = ^bus.din[REG_WIDTH-1:INSTRUCTION_WIDTH];

  assign opcode = ir_q[8:6];
  assign xSel   = ir_q[5:3];
  assign ySel   = ir_q[2:0];

  function automatic logic [7:0] oneHot(input logic [2:0] sel);
    return 8'b0000_0001 << sel;
  endfunction

  // Classify the latched opcode: which ones use the A/G multi-step sequence and with which ALU op
  always_comb begin
    isArith    = 1'b0;
    arithAluOp = ALU_ADD;
    case (opcode)
      OP_ADD: begin
        isArith    = 1'b1;
        arithAluOp = ALU_ADD;
      end
      OP_SUB: begin
        isArith    = 1'b1;
        arithAluOp = ALU_SUB;
      end
`ifdef PROC_CTRL_AND_EN
      OP_AND: begin
        isArith    = 1'b1;
        arithAluOp = ALU_AND;
      end
`endif
      default: begin
        isArith    = 1'b0;
        arithAluOp = ALU_ADD;
      end
    endcase
  end

  // State register: step counter and instruction register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  // Next-state logic: capture on run in T0, short path for MV/MVI/illegal, long path for arithmetic
  always_comb begin
    step_d = step_q;
    ir_d   = ir_q;
    case (step_q)
      T0: begin
        if (bus.run) begin
          ir_d   = bus.din[INSTRUCTION_WIDTH-1:0];
          step_d = T1;
        end
      end
      T1: begin
        step_d = isArith ? T2 : T0;
      end
      T2: begin
        step_d = isArith ? T3 : T0;
      end
      T3: begin
        step_d = T0;
      end
      default: begin
        step_d = T0;
      end
    endcase
  end

  // Output decode: every enable is a function of step and IR, forced low while reset is held
  always_comb begin
    irInVal    = 1'b0;
    rInVal     = 8'h00;
    rOutVal    = 8'h00;
    dinOutVal  = 1'b0;
    aInVal     = 1'b0;
    gInVal     = 1'b0;
    gOutVal    = 1'b0;
    aluOpVal   = ALU_ADD;
    doneVal    = 1'b0;
    illegalVal = 1'b0;
    if (!rst) begin
      case (step_q)
        T0: begin
          irInVal = bus.run;
        end
        T1: begin
          if (opcode == OP_MV) begin
            rOutVal = oneHot(ySel);
            rInVal  = oneHot(xSel);
            doneVal = 1'b1;
          end else if (opcode == OP_MVI) begin
            dinOutVal = 1'b1;
            rInVal    = oneHot(xSel);
            doneVal   = 1'b1;
          end else if (isArith) begin
            rOutVal = oneHot(xSel);
            aInVal  = 1'b1;
          end else begin
            illegalVal = 1'b1;
            doneVal    = 1'b1;
          end
        end
        T2: begin
          if (isArith) begin
            rOutVal  = oneHot(ySel);
            gInVal   = 1'b1;
            aluOpVal = arithAluOp;
          end
        end
        T3: begin
          if (isArith) begin
            gOutVal = 1'b1;
            rInVal  = oneHot(xSel);
            doneVal = 1'b1;
          end
        end
        default: begin
          irInVal = 1'b0;
        end
      endcase
    end
  end

  assign bus.ir_in   = irInVal;
  assign bus.r_in    = rInVal;
  assign bus.r_out   = rOutVal;
  assign bus.din_out = dinOutVal;
  assign bus.a_in    = aInVal;
  assign bus.g_in    = gInVal;
  assign bus.g_out   = gOutVal;
  assign bus.alu_op  = aluOpVal;
  assign bus.done    = doneVal;
  assign bus.illegal = illegalVal;
  assign bus.step    = rst ? '0 : step_q;

endmodule
